mc_ctrl_trap: RTL and testbench
===============================

Name: mc_ctrl_trap

Overview:
- Parametrised successor to the multicycle MIPS control FSM: same datapath control vector, same ALU encoding.
- Adds memory wait handling in every memory state, a configurable memory timeout, and jalr.
- Replaces the dead-end Error state with a trap sequence to an exception vector, records EPC/cause, and keeps an instruction-retired counter.
- Sits between the instruction register and the multicycle datapath/MIO bus.

Parameters:
MEM_WAIT_MAX, 15, MIO_ready-low cycles tolerated in IF/MEM_RD/MEM_WD before timeout trap; 0 = never time out
CNT_W, 32, width of instr_retired
EN_OVF_TRAP, 1, 1 = signed overflow on add/sub/addi traps; 0 = ignored, write back normally

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
Inst_in  in  32  current instruction register
zero  in  1  ALU zero
overflow  in  1  ALU signed overflow
MIO_ready  in  1  memory/bus ready
MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1 each  datapath controls
RegDst, MemtoReg, ALUSrcB, PCSource  out  2 each  datapath selects; PCSource=11 selects exception vector
ALU_operation  out  3  AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111
state_out  out  5  current state
EPCWrite  out  1  latch PC into EPC
exc_cause  out  2  last trap cause: 00 none, 01 illegal, 10 overflow, 11 mem timeout
instr_retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset (reset=0 at posedge): state<=IF, wait counter<=0, exc_cause<=00, instr_retired<=0. While reset=0, PCWrite/IRWrite/MemRead/MemWrite/RegWrite/EPCWrite forced 0.
- Outputs: Moore decode of state, plus the MIO_ready gating in IF. Defaults: all 0, ALU_operation=ADD, Branch=1.
- States and encodings:
  - IF 00000, ID 00001, EX_MEM 00010, MEM_RD 00011, WB_LW 00100, MEM_WD 00101
  - EX_R 00110, WB_R 00111, EX_BEQ 01000, EX_J 01001, EX_I 01010, WB_I 01011
  - LUI_WB 01100, EX_BNE 01101, EX_JR 01110, EX_JAL 01111, EX_JALR 10000, TRAP 10001
- Per-state controls:
  - IF: MemRead, CPU_MIO, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00. IRWrite and PCWrite asserted only when MIO_ready=1. Stays in IF until MIO_ready, then goes to ID.
  - ID: ALUSrcA=0, ALUSrcB=11. Next state by opcode:
    - lw/sw -> EX_MEM; beq -> EX_BEQ; bne -> EX_BNE
    - addi/andi/ori/xori/slti/lui -> EX_I; j -> EX_J; jal -> EX_JAL
    - opcode 0: funct 001000 -> EX_JR; funct 001001 -> EX_JALR; else EX_R
    - any other opcode -> TRAP, cause 01
  - EX_MEM: ALUSrcA=1, ALUSrcB=10, ADD. lw -> MEM_RD, sw -> MEM_WD.
  - MEM_RD: MemRead, IorD=1, CPU_MIO. Goes to WB_LW on MIO_ready.
  - MEM_WD: MemWrite, IorD=1, CPU_MIO. Goes to IF on MIO_ready.
  - WB_LW: RegWrite, RegDst=00, MemtoReg=01.
  - EX_R: ALUSrcA=1, ALUSrcB=00. Funct -> op: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000010 SRL, 100110 XOR; others ADD. Goes to WB_R.
  - WB_R: RegWrite, RegDst=01, MemtoReg=00.
  - EX_BEQ / EX_BNE: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=01. Branch=1 for EX_BEQ, 0 for EX_BNE. Both go to IF.
  - EX_I: ALUSrcA=1, ALUSrcB=10. Opcode -> op: addi ADD, andi AND, ori OR, xori XOR, slti SLT. lui -> LUI_WB; others -> WB_I.
  - WB_I: RegWrite, RegDst=00, MemtoReg=00.
  - LUI_WB: RegWrite, RegDst=00, MemtoReg=10.
  - EX_J: PCWrite, PCSource=10.
  - EX_JR: PCWrite, PCSource=00, ALUSrcA=1, ALUSrcB=00, ADD.
  - EX_JAL: PCWrite, PCSource=10, RegWrite, RegDst=10, MemtoReg=11.
  - EX_JALR: as EX_JR, plus RegWrite, RegDst=01, MemtoReg=11.
  - TRAP: PCWrite, PCSource=11, EPCWrite. Goes to IF.
- Overflow trap: when EN_OVF_TRAP=1 and overflow=1 in EX_R (funct 100000/100010) or EX_I (addi), next state is TRAP with cause 10. No writeback occurs.
- Wait counter:
  - Increments each cycle the FSM stays in IF/MEM_RD/MEM_WD with MIO_ready=0; cleared on any state change.
  - When the counter equals MEM_WAIT_MAX-1 and MIO_ready=0, next state is TRAP with cause 11.
  - MIO_ready=1 in the same cycle wins over timeout.
- exc_cause: updated on the edge entering TRAP; holds otherwise.
- instr_retired: +1 on every transition into IF from any state other than TRAP or IF; wraps modulo 2^CNT_W.
- Unreachable encodings go to TRAP with cause 01.
- Reset asserted mid-instruction aborts at the next edge, with no retire count.

Test Plan:
- lw (0x8C010004), MIO_ready low 3 cycles in MEM_RD -> sequence IF,ID,EX_MEM,MEM_RD x4,WB_LW,IF; RegWrite=1 only in WB_LW with MemtoReg=01; instr_retired 0->1.
- Opcode 0x3F in ID -> TRAP next cycle with PCWrite=1, PCSource=11, EPCWrite=1, then IF; exc_cause=01; instr_retired unchanged.
- add (funct 100000) with overflow=1 in EX_R -> TRAP, cause 10, no WB_R. Repeat with EN_OVF_TRAP=0 -> WB_R, RegWrite=1.
- MEM_WAIT_MAX=4, sw with MIO_ready held 0 -> 4 cycles in MEM_WD, then TRAP, cause 11. MIO_ready=1 on the 4th cycle -> IF instead.
- jalr (funct 001001) -> EX_JALR with PCWrite=1, RegWrite=1, RegDst=01, MemtoReg=11, PCSource=00. bne -> Branch=0, ALU_operation=110, PCWriteCond=1.
- reset=0 during MEM_RD -> state_out=00000 next edge, counters 0, write enables 0 while low; CNT_W=2 with 5 instructions -> instr_retired=1.

Source files
------------

// File: rtl/mc_ctrl_trap_if.sv
// Control bus between the multicycle MIPS controller and its datapath / MIO bus.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface mc_ctrl_trap_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      Inst_in;
  logic             zero;
  logic             overflow;
  logic             MIO_ready;

  logic             MemRead;
  logic             MemWrite;
  logic             CPU_MIO;
  logic             IorD;
  logic             IRWrite;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             Branch;
  logic             EPCWrite;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic [1:0]       ALUSrcB;
  logic [1:0]       PCSource;
  logic [2:0]       ALU_operation;
  logic [4:0]       state_out;
  logic [1:0]       exc_cause;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  Inst_in, zero, overflow, MIO_ready,
    output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
           PCWrite, PCWriteCond, Branch, EPCWrite, RegDst, MemtoReg, ALUSrcB,
           PCSource, ALU_operation, state_out, exc_cause, instr_retired
  );

  modport slave (
    output Inst_in, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA,
           PCWrite, PCWriteCond, Branch, EPCWrite, RegDst, MemtoReg, ALUSrcB,
           PCSource, ALU_operation, state_out, exc_cause, instr_retired
  );
endinterface

// File: rtl/mc_ctrl_trap.sv
// Multicycle MIPS control FSM with memory-wait timeout, jalr, and a trap path
// to the exception vector that records the cause and counts retired instructions.
module mc_ctrl_trap #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32,
  parameter bit EN_OVF_TRAP  = 1'b1
) (
  input logic           clk,
  input logic           reset,
  mc_ctrl_trap_if.master bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  typedef enum logic [4:0] {
    S_IF      = 5'b00000, S_ID     = 5'b00001, S_EX_MEM = 5'b00010,
    S_MEM_RD  = 5'b00011, S_WB_LW  = 5'b00100, S_MEM_WD = 5'b00101,
    S_EX_R    = 5'b00110, S_WB_R   = 5'b00111, S_EX_BEQ = 5'b01000,
    S_EX_J    = 5'b01001, S_EX_I   = 5'b01010, S_WB_I   = 5'b01011,
    S_LUI_WB  = 5'b01100, S_EX_BNE = 5'b01101, S_EX_JR  = 5'b01110,
    S_EX_JAL  = 5'b01111, S_EX_JALR = 5'b10000, S_TRAP  = 5'b10001
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02, FN_JR  = 6'h08, FN_JALR = 6'h09,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND  = 6'h24,
                         FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010,
                         ALU_XOR = 3'b011, ALU_NOR = 3'b100, ALU_SRL = 3'b101,
                         ALU_SUB = 3'b110, ALU_SLT = 3'b111;

  localparam logic [1:0] CAUSE_ILL = 2'b01, CAUSE_OVF = 2'b10, CAUSE_TMO = 2'b11;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ovfTrap;
  logic       memWait;
  logic [1:0] trapCause;

  assign opcode  = bus.Inst_in[31:26];
  assign funct   = bus.Inst_in[5:0];
  assign ovfTrap = EN_OVF_TRAP && bus.overflow;

  logic unused_ok;
  assign unused_ok = ^{bus.zero, bus.Inst_in[25:6]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IF;
      waitCnt_q <= '0;
      cause_q   <= 2'b00;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    cause_d   = cause_q;
    retired_d = retired_q;
    memWait   = 1'b0;
    trapCause = CAUSE_ILL;

    case (state_q)
      S_IF:     if (bus.MIO_ready) state_d = S_ID; else memWait = 1'b1;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_EX_MEM;
          OP_BEQ:       state_d = S_EX_BEQ;
          OP_BNE:       state_d = S_EX_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: state_d = S_EX_I;
          OP_J:         state_d = S_EX_J;
          OP_JAL:       state_d = S_EX_JAL;
          OP_RTYPE: begin
            if (funct == FN_JR)        state_d = S_EX_JR;
            else if (funct == FN_JALR) state_d = S_EX_JALR;
            else                       state_d = S_EX_R;
          end
          default:      state_d = S_TRAP;
        endcase
      end
      S_EX_MEM: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WD;
        else                      state_d = S_TRAP;
      end
      S_MEM_RD: if (bus.MIO_ready) state_d = S_WB_LW; else memWait = 1'b1;
      S_MEM_WD: if (bus.MIO_ready) state_d = S_IF;    else memWait = 1'b1;
      S_EX_R: begin
        if (ovfTrap && (funct == FN_ADD || funct == FN_SUB)) begin
          state_d   = S_TRAP;
          trapCause = CAUSE_OVF;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EX_I: begin
        if (opcode == OP_LUI) begin
          state_d = S_LUI_WB;
        end else if (ovfTrap && opcode == OP_ADDI) begin
          state_d   = S_TRAP;
          trapCause = CAUSE_OVF;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_WB_LW, S_WB_R, S_WB_I, S_LUI_WB, S_EX_BEQ, S_EX_BNE,
      S_EX_J, S_EX_JR, S_EX_JAL, S_EX_JALR, S_TRAP: state_d = S_IF;
      default: state_d = S_TRAP;
    endcase

    // A ready in the last tolerated cycle was handled above and never reaches here.
    if (memWait) begin
      if (MEM_WAIT_MAX != 0 && waitCnt_q == WAIT_LAST) begin
        state_d   = S_TRAP;
        trapCause = CAUSE_TMO;
      end else begin
        waitCnt_d = waitCnt_q + WAIT_W'(1);
      end
    end

    if (state_d == S_TRAP && state_q != S_TRAP) cause_d = trapCause;

    if (state_d == S_IF && state_q != S_IF && state_q != S_TRAP)
      retired_d = retired_q + CNT_W'(1);
  end

  always_comb begin
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.CPU_MIO       = 1'b0;
    bus.IorD          = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.ALUSrcA       = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.Branch        = 1'b1;
    bus.EPCWrite      = 1'b0;
    bus.RegDst        = 2'b00;
    bus.MemtoReg      = 2'b00;
    bus.ALUSrcB       = 2'b00;
    bus.PCSource      = 2'b00;
    bus.ALU_operation = ALU_ADD;

    case (state_q)
      S_IF: begin
        bus.MemRead = 1'b1;
        bus.CPU_MIO = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MIO_ready;
        bus.PCWrite = bus.MIO_ready;
      end
      S_ID:     bus.ALUSrcB = 2'b11;
      S_EX_MEM: begin bus.ALUSrcA = 1'b1; bus.ALUSrcB = 2'b10; end
      S_MEM_RD: begin bus.MemRead = 1'b1; bus.IorD = 1'b1; bus.CPU_MIO = 1'b1; end
      S_MEM_WD: begin bus.MemWrite = 1'b1; bus.IorD = 1'b1; bus.CPU_MIO = 1'b1; end
      S_WB_LW:  begin bus.RegWrite = 1'b1; bus.MemtoReg = 2'b01; end
      S_EX_R: begin
        bus.ALUSrcA = 1'b1;
        case (funct)
          FN_SUB:  bus.ALU_operation = ALU_SUB;
          FN_AND:  bus.ALU_operation = ALU_AND;
          FN_OR:   bus.ALU_operation = ALU_OR;
          FN_NOR:  bus.ALU_operation = ALU_NOR;
          FN_SLT:  bus.ALU_operation = ALU_SLT;
          FN_SRL:  bus.ALU_operation = ALU_SRL;
          FN_XOR:  bus.ALU_operation = ALU_XOR;
          default: bus.ALU_operation = ALU_ADD;
        endcase
      end
      S_WB_R:   begin bus.RegWrite = 1'b1; bus.RegDst = 2'b01; end
      S_EX_BEQ, S_EX_BNE: begin
        bus.ALUSrcA       = 1'b1;
        bus.ALU_operation = ALU_SUB;
        bus.PCWriteCond   = 1'b1;
        bus.PCSource      = 2'b01;
        bus.Branch        = (state_q == S_EX_BEQ);
      end
      S_EX_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: bus.ALU_operation = ALU_AND;
          OP_ORI:  bus.ALU_operation = ALU_OR;
          OP_XORI: bus.ALU_operation = ALU_XOR;
          OP_SLTI: bus.ALU_operation = ALU_SLT;
          default: bus.ALU_operation = ALU_ADD;
        endcase
      end
      S_WB_I:   bus.RegWrite = 1'b1;
      S_LUI_WB: begin bus.RegWrite = 1'b1; bus.MemtoReg = 2'b10; end
      S_EX_J:   begin bus.PCWrite = 1'b1; bus.PCSource = 2'b10; end
      S_EX_JR:  begin bus.PCWrite = 1'b1; bus.ALUSrcA = 1'b1; end
      S_EX_JAL: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b11;
      end
      S_EX_JALR: begin
        bus.PCWrite  = 1'b1;
        bus.ALUSrcA  = 1'b1;
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b01;
        bus.MemtoReg = 2'b11;
      end
      S_TRAP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
        bus.EPCWrite = 1'b1;
      end
      default: ;
    endcase

    // Nothing may be written to memory, registers or PC while held in reset.
    if (!reset) begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.EPCWrite = 1'b0;
    end
  end

  assign bus.state_out     = state_q;
  assign bus.exc_cause     = cause_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_trap.sv
// Scoreboard bench for mc_ctrl_trap: two instances (default and small-timeout/
// no-overflow-trap/2-bit counter) driven by directed instruction sequences.
module tb_mc_ctrl_trap;

  typedef enum int {
    F_STATE, F_MEMREAD, F_MEMWRITE, F_IORD, F_IRWRITE, F_REGWRITE, F_ALUSRCA,
    F_PCWRITE, F_PCWCOND, F_BRANCH, F_EPCWRITE, F_REGDST, F_MEMTOREG,
    F_ALUSRCB, F_PCSOURCE, F_ALUOP, F_CAUSE, F_RETIRED
  } field_e;

  typedef struct {
    int          cyc;
    int          sel;
    field_e      f;
    logic [31:0] v;
    string       name;
  } sb_item_t;

  localparam logic [31:0] I_LW   = 32'h8C010004, I_ILL = 32'hFC000000,
                          I_ADD  = 32'h00221820, I_SUB = 32'h00221822,
                          I_JALR = 32'h0020F809, I_BNE = 32'h14220003,
                          I_ORI  = 32'h34210005, I_SW  = 32'hAC010004,
                          I_J    = 32'h08000010, I_BEQ = 32'h10220002,
                          I_JAL  = 32'h0C000010;

  localparam logic [31:0] ST_IF = 0, ST_ID = 1, ST_EX_MEM = 2, ST_MEM_RD = 3,
                          ST_WB_LW = 4, ST_MEM_WD = 5, ST_EX_R = 6, ST_WB_R = 7,
                          ST_EX_BEQ = 8, ST_EX_J = 9, ST_EX_I = 10, ST_WB_I = 11,
                          ST_EX_BNE = 13, ST_EX_JAL = 15, ST_EX_JALR = 16,
                          ST_TRAP = 17;

  logic clk;
  logic rst0, rst1;
  int   cyc = 0;
  int   curSel = 0;
  int   errors = 0;
  int   checks = 0;
  sb_item_t sbQ[$];
  sb_item_t item;

  mc_ctrl_trap_if #(.CNT_W(32)) bus0 ();
  mc_ctrl_trap_if #(.CNT_W(2))  bus1 ();

  mc_ctrl_trap #(.MEM_WAIT_MAX(15), .CNT_W(32), .EN_OVF_TRAP(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );
  mc_ctrl_trap #(.MEM_WAIT_MAX(4), .CNT_W(2), .EN_OVF_TRAP(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] getField(input int sel, input field_e f);
    case (f)
      F_STATE:    return sel == 0 ? 32'(bus0.state_out)     : 32'(bus1.state_out);
      F_MEMREAD:  return sel == 0 ? 32'(bus0.MemRead)       : 32'(bus1.MemRead);
      F_MEMWRITE: return sel == 0 ? 32'(bus0.MemWrite)      : 32'(bus1.MemWrite);
      F_IORD:     return sel == 0 ? 32'(bus0.IorD)          : 32'(bus1.IorD);
      F_IRWRITE:  return sel == 0 ? 32'(bus0.IRWrite)       : 32'(bus1.IRWrite);
      F_REGWRITE: return sel == 0 ? 32'(bus0.RegWrite)      : 32'(bus1.RegWrite);
      F_ALUSRCA:  return sel == 0 ? 32'(bus0.ALUSrcA)       : 32'(bus1.ALUSrcA);
      F_PCWRITE:  return sel == 0 ? 32'(bus0.PCWrite)       : 32'(bus1.PCWrite);
      F_PCWCOND:  return sel == 0 ? 32'(bus0.PCWriteCond)   : 32'(bus1.PCWriteCond);
      F_BRANCH:   return sel == 0 ? 32'(bus0.Branch)        : 32'(bus1.Branch);
      F_EPCWRITE: return sel == 0 ? 32'(bus0.EPCWrite)      : 32'(bus1.EPCWrite);
      F_REGDST:   return sel == 0 ? 32'(bus0.RegDst)        : 32'(bus1.RegDst);
      F_MEMTOREG: return sel == 0 ? 32'(bus0.MemtoReg)      : 32'(bus1.MemtoReg);
      F_ALUSRCB:  return sel == 0 ? 32'(bus0.ALUSrcB)       : 32'(bus1.ALUSrcB);
      F_PCSOURCE: return sel == 0 ? 32'(bus0.PCSource)      : 32'(bus1.PCSource);
      F_ALUOP:    return sel == 0 ? 32'(bus0.ALU_operation) : 32'(bus1.ALU_operation);
      F_CAUSE:    return sel == 0 ? 32'(bus0.exc_cause)     : 32'(bus1.exc_cause);
      F_RETIRED:  return sel == 0 ? 32'(bus0.instr_retired) : 32'(bus1.instr_retired);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input sb_item_t it);
    logic [31:0] actual;
    actual = getField(it.sel, it.f);
    checks++;
    if (actual !== it.v) begin
      errors++;
      $display("[TB] FAIL %s (dut%0d, cycle %0d): got %0h, expected %0h",
               it.name, it.sel, it.cyc, actual, it.v);
    end
  endtask

  // Monitor: compares every expectation tagged for the cycle the DUT is now presenting.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
      item = sbQ.pop_front();
      checkOutput(item);
    end
  end

  task automatic applyStimulus(input logic rstN, input logic [31:0] inst,
                               input logic ovf, input logic rdy);
    if (curSel == 0) begin
      rst0 = rstN; bus0.Inst_in = inst; bus0.overflow = ovf; bus0.MIO_ready = rdy; bus0.zero = 1'b0;
    end else begin
      rst1 = rstN; bus1.Inst_in = inst; bus1.overflow = ovf; bus1.MIO_ready = rdy; bus1.zero = 1'b0;
    end
  endtask

  task automatic expectField(input string name, input field_e f, input logic [31:0] v);
    sb_item_t it;
    it.cyc  = cyc;
    it.sel  = curSel;
    it.f    = f;
    it.v    = v;
    it.name = name;
    sbQ.push_back(it);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchDecode(input string tag, input logic [31:0] inst,
                             input logic [31:0] expRetired);
    tick();
    applyStimulus(1'b1, inst, 1'b0, 1'b1);
    expectField({tag, " IF state"}, F_STATE, ST_IF);
    expectField({tag, " retired"}, F_RETIRED, expRetired);
    tick();
    applyStimulus(1'b1, inst, 1'b0, 1'b0);
    expectField({tag, " ID state"}, F_STATE, ST_ID);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    curSel = 1; applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    curSel = 0; applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset state on both instances, with ready high to prove write gating
    tick();
    for (int s = 0; s < 2; s++) begin
      curSel = s;
      expectField("rst state", F_STATE, ST_IF);
      expectField("rst PCWrite", F_PCWRITE, 0);
      expectField("rst IRWrite", F_IRWRITE, 0);
      expectField("rst MemRead", F_MEMREAD, 0);
      expectField("rst retired", F_RETIRED, 0);
      expectField("rst cause", F_CAUSE, 0);
    end
    curSel = 0;

    // lw with three wait cycles in MEM_RD
    tick();
    applyStimulus(1'b1, I_LW, 1'b0, 1'b1);
    expectField("lw IF state", F_STATE, ST_IF);
    expectField("lw IF IRWrite", F_IRWRITE, 1);
    expectField("lw IF PCWrite", F_PCWRITE, 1);
    expectField("lw IF MemRead", F_MEMREAD, 1);
    expectField("lw IF ALUSrcB", F_ALUSRCB, 1);
    tick();
    applyStimulus(1'b1, I_LW, 1'b0, 1'b0);
    expectField("lw ID state", F_STATE, ST_ID);
    expectField("lw ID ALUSrcB", F_ALUSRCB, 3);
    tick();
    expectField("lw EX_MEM state", F_STATE, ST_EX_MEM);
    expectField("lw EX_MEM ALUSrcB", F_ALUSRCB, 2);
    expectField("lw EX_MEM ALUop", F_ALUOP, 3'b010);
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(1'b1, I_LW, 1'b0, k == 3);
      expectField("lw MEM_RD state", F_STATE, ST_MEM_RD);
      expectField("lw MEM_RD MemRead", F_MEMREAD, 1);
      expectField("lw MEM_RD IorD", F_IORD, 1);
      expectField("lw MEM_RD RegWrite", F_REGWRITE, 0);
    end
    tick();
    expectField("lw WB state", F_STATE, ST_WB_LW);
    expectField("lw WB RegWrite", F_REGWRITE, 1);
    expectField("lw WB MemtoReg", F_MEMTOREG, 1);
    expectField("lw WB retired", F_RETIRED, 0);

    // Illegal opcode traps straight from ID
    fetchDecode("ill", I_ILL, 1);
    tick();
    expectField("ill TRAP state", F_STATE, ST_TRAP);
    expectField("ill TRAP PCWrite", F_PCWRITE, 1);
    expectField("ill TRAP PCSource", F_PCSOURCE, 3);
    expectField("ill TRAP EPCWrite", F_EPCWRITE, 1);
    expectField("ill TRAP cause", F_CAUSE, 1);

    // add overflow traps with cause 10 and no writeback
    fetchDecode("addovf", I_ADD, 1);
    tick();
    applyStimulus(1'b1, I_ADD, 1'b1, 1'b0);
    expectField("addovf EX_R state", F_STATE, ST_EX_R);
    expectField("addovf EX_R ALUop", F_ALUOP, 3'b010);
    expectField("addovf EX_R ALUSrcA", F_ALUSRCA, 1);
    tick();
    applyStimulus(1'b1, I_ADD, 1'b0, 1'b0);
    expectField("addovf TRAP state", F_STATE, ST_TRAP);
    expectField("addovf TRAP cause", F_CAUSE, 2);
    expectField("addovf TRAP RegWrite", F_REGWRITE, 0);

    // jalr
    fetchDecode("jalr", I_JALR, 1);
    tick();
    expectField("jalr state", F_STATE, ST_EX_JALR);
    expectField("jalr PCWrite", F_PCWRITE, 1);
    expectField("jalr RegWrite", F_REGWRITE, 1);
    expectField("jalr RegDst", F_REGDST, 1);
    expectField("jalr MemtoReg", F_MEMTOREG, 3);
    expectField("jalr PCSource", F_PCSOURCE, 0);

    // bne
    fetchDecode("bne", I_BNE, 2);
    tick();
    expectField("bne state", F_STATE, ST_EX_BNE);
    expectField("bne Branch", F_BRANCH, 0);
    expectField("bne ALUop", F_ALUOP, 3'b110);
    expectField("bne PCWriteCond", F_PCWCOND, 1);
    expectField("bne PCSource", F_PCSOURCE, 1);
    expectField("bne PCWrite", F_PCWRITE, 0);

    // sub without overflow writes back
    fetchDecode("sub", I_SUB, 3);
    tick();
    expectField("sub EX_R ALUop", F_ALUOP, 3'b110);
    tick();
    expectField("sub WB_R state", F_STATE, ST_WB_R);
    expectField("sub WB_R RegWrite", F_REGWRITE, 1);
    expectField("sub WB_R RegDst", F_REGDST, 1);

    // ori through EX_I / WB_I
    fetchDecode("ori", I_ORI, 4);
    tick();
    expectField("ori EX_I state", F_STATE, ST_EX_I);
    expectField("ori EX_I ALUop", F_ALUOP, 3'b001);
    expectField("ori EX_I ALUSrcB", F_ALUSRCB, 2);
    tick();
    expectField("ori WB_I state", F_STATE, ST_WB_I);
    expectField("ori WB_I RegWrite", F_REGWRITE, 1);

    // Reset asserted while waiting in MEM_RD
    fetchDecode("lwrst", I_LW, 5);
    tick();
    tick();
    applyStimulus(1'b0, I_LW, 1'b0, 1'b0);
    expectField("lwrst MEM_RD state", F_STATE, ST_MEM_RD);
    expectField("lwrst MEM_RD MemRead gated", F_MEMREAD, 0);
    tick();
    applyStimulus(1'b0, I_LW, 1'b0, 1'b1);
    expectField("lwrst state", F_STATE, ST_IF);
    expectField("lwrst retired", F_RETIRED, 0);
    expectField("lwrst cause", F_CAUSE, 0);
    expectField("lwrst IRWrite", F_IRWRITE, 0);
    expectField("lwrst PCWrite", F_PCWRITE, 0);

    // Second instance: no overflow trap, 4-cycle timeout, 2-bit counter
    curSel = 1;
    fetchDecode("d1 add", I_ADD, 0);
    tick();
    applyStimulus(1'b1, I_ADD, 1'b1, 1'b0);
    expectField("d1 add EX_R state", F_STATE, ST_EX_R);
    tick();
    applyStimulus(1'b1, I_ADD, 1'b0, 1'b0);
    expectField("d1 add WB_R state", F_STATE, ST_WB_R);
    expectField("d1 add WB_R RegWrite", F_REGWRITE, 1);

    fetchDecode("d1 swtmo", I_SW, 1);
    tick();
    expectField("d1 swtmo EX_MEM", F_STATE, ST_EX_MEM);
    for (int k = 0; k < 4; k++) begin
      tick();
      expectField("d1 swtmo MEM_WD state", F_STATE, ST_MEM_WD);
      expectField("d1 swtmo MemWrite", F_MEMWRITE, 1);
    end
    tick();
    expectField("d1 swtmo TRAP state", F_STATE, ST_TRAP);
    expectField("d1 swtmo cause", F_CAUSE, 3);

    fetchDecode("d1 swok", I_SW, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(1'b1, I_SW, 1'b0, k == 3);
      expectField("d1 swok MEM_WD state", F_STATE, ST_MEM_WD);
    end

    fetchDecode("d1 j", I_J, 2);
    tick();
    expectField("d1 j state", F_STATE, ST_EX_J);
    expectField("d1 j PCWrite", F_PCWRITE, 1);
    expectField("d1 j PCSource", F_PCSOURCE, 2);

    fetchDecode("d1 beq", I_BEQ, 3);
    tick();
    expectField("d1 beq state", F_STATE, ST_EX_BEQ);
    expectField("d1 beq Branch", F_BRANCH, 1);
    expectField("d1 beq PCWriteCond", F_PCWCOND, 1);

    fetchDecode("d1 jal", I_JAL, 0);
    tick();
    expectField("d1 jal state", F_STATE, ST_EX_JAL);
    expectField("d1 jal RegDst", F_REGDST, 2);
    expectField("d1 jal MemtoReg", F_MEMTOREG, 3);
    tick();
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    expectField("d1 wrap retired", F_RETIRED, 1);
    expectField("d1 wrap cause", F_CAUSE, 3);

    tick();
    tick();
    if (sbQ.size() != 0) begin
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sbQ.size());
      errors += sbQ.size();
      checks += sbQ.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
